// File: rtl/match_event_logger.sv
// match_event_logger
//   Timestamps each match pulse from the serial 11101 detector with a
//   free-running cycle counter. Buffers the stamps in a FIFO that is drained
//   over a valid/ready handshake. Keeps saturating match and drop statistics
//   and a sticky overflow flag, so the always-on detector is isolated from a
//   readout agent that may stall.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high; overrides clear and all activity
//   match_in     detector match pulse; one match per high cycle
//   clear        synchronous flush of FIFO, statistics and overflow
//                (the timestamp counter is not affected)
//   out_valid    FIFO head holds a timestamp
//   out_ready    consumer accepts the head this cycle
//   out_ts       timestamp at the FIFO head
//   match_count  push attempts since reset/clear, saturating
//   drop_count   pushes discarded because the FIFO was full, saturating
//   overflow     sticky: at least one drop since reset/clear
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             match_in,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TS_W-1:0]  out_ts,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic             pop;
  logic             push_try;
  logic             full;
  logic             push;
  logic             drop;
  logic [PTR_W-1:0] rd_next;
  logic [OCC_W-1:0] occ_next;
  logic [TS_W-1:0]  head_next;

  // Free-running timestamp; independent of clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  always_comb begin
    pop       = out_valid & out_ready;
    push_try  = match_in & ~clear;
    full      = (occ == FULL_OCC);
    // When full, a simultaneous pop frees the slot the push lands in.
    push      = push_try & (~full | pop);
    drop      = push_try & full & ~pop;
    rd_next   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    occ_next  = occ + OCC_W'(push) - OCC_W'(pop);
    // The head is kept in its own register so out_ts is a flop output.
    // If the entry becoming head is the one written this cycle, the
    // memory does not hold it yet, so forward the timestamp directly.
    head_next = (push && (wr_ptr == rd_next)) ? ts : mem[rd_next];
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= ts;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
      if (reset) begin
        out_ts <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_next;
      occ       <= occ_next;
      out_valid <= (occ_next != '0);
      if (occ_next != '0) begin
        out_ts <= head_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      match_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push_try && (match_count != '1)) begin
        match_count <= match_count + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule
